// File: rtl/piezo_pkg.sv
// Shared constants and types for the piezo tone detector and tone generator.
package piezo_pkg;

   typedef logic [3:0] note_t;

   typedef enum logic [1:0] {IDLE, ARM, MEASURE, LOCKED} state_t;

   localparam note_t NOTE_NONE = 4'd0;

   // Nominal half-periods in clk cycles, index 1 = C4 .. 8 = C5.
   localparam logic [8:1][10:0] NOM_HALF = {
      11'd479, 11'd507, 11'd569, 11'd639, 11'd717, 11'd759, 11'd852, 11'd957
   };

   // Segments a..g,dp in bits 7..0; index 0 is the "none" digit.
   localparam logic [8:0][7:0] FND_DIGIT = {
      8'b11111110, 8'b11100000, 8'b10111110, 8'b10110110, 8'b01100110,
      8'b11110010, 8'b11011010, 8'b01100000, 8'b11111100
   };

   function automatic note_t classify(input logic [10:0] m, input int tol);
      note_t r = NOTE_NONE;
      for (int k = 1; k <= 8; k++) begin
         int d = int'(m) - int'(NOM_HALF[k]);
         if (r == NOTE_NONE && d <= tol && d >= -tol) r = note_t'(k);
      end
      return r;
   endfunction

   function automatic logic [7:0] onehot_of(input note_t n);
      logic [7:0] s = '0;
      if (n >= 4'd1 && n <= 4'd8) s = 8'h80 >> (n - 4'd1);
      return s;
   endfunction

   function automatic logic [7:0] fnd_of(input note_t n);
      if (n > 4'd8) return FND_DIGIT[0];
      return FND_DIGIT[n];
   endfunction

endpackage

// File: rtl/piezo_tone_detect_if.sv
// Tone input and note outputs of the piezo tone detector.
interface piezo_tone_detect_if;
   logic       tone_in;
   logic [3:0] note;
   logic       note_valid;
   logic [7:0] note_sw;
   logic [7:0] FND_out;

   modport master (output tone_in, input note, note_valid, note_sw, FND_out);
   modport slave  (input tone_in, output note, note_valid, note_sw, FND_out);
endinterface

// File: rtl/tone_sync_edge.sv
// Two-flop synchroniser plus history flop; emits a registered one-cycle edge pulse.
module tone_sync_edge (
   input  logic clk,
   input  logic rst_n,
   input  logic din,
   output logic edge_o
);
   logic s1_q, s2_q, hist_q, edge_q;
   logic s1_d, s2_d, hist_d, edge_d;

   always_comb begin
      s1_d   = din;
      s2_d   = s1_q;
      hist_d = s2_q;
      edge_d = s2_q ^ hist_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s1_q   <= 1'b0;
         s2_q   <= 1'b0;
         hist_q <= 1'b0;
         edge_q <= 1'b0;
      end else begin
         s1_q   <= s1_d;
         s2_q   <= s2_d;
         hist_q <= hist_d;
         edge_q <= edge_d;
      end
   end

   assign edge_o = edge_q;
endmodule

// File: rtl/piezo_tone_detect.sv
// Measures tone_in half-periods and locks onto one of eight notes.
// TONE_DET_CONFIRM_EN: require CONFIRM matching half-periods before locking.
module piezo_tone_detect
   import piezo_pkg::*;
#(
   parameter int TOL     = 8,
   parameter int TIMEOUT = 2047,
   parameter int CONFIRM = 2
) (
   input logic               clk,
   input logic               rst_n,
   piezo_tone_detect_if.slave io
);
`ifdef TONE_DET_CONFIRM_EN
   localparam int NEED = CONFIRM;
`else
   localparam int NEED = 1 + 0 * CONFIRM;
`endif
   localparam logic [3:0]  NEED_W = 4'(NEED);
   localparam logic [10:0] TMO    = 11'(TIMEOUT);

   logic        edge_pulse;
   logic [10:0] cnt_q, cnt_d;
   state_t      state_q, state_d;
   note_t       cand_q, cand_d, note_q, note_d, hit;
   logic [3:0]  mcnt_q, mcnt_d;
   logic        vld_q, vld_d;
   logic [7:0]  sw_q, sw_d, fnd_q, fnd_d;

   tone_sync_edge u_sync (.clk(clk), .rst_n(rst_n), .din(io.tone_in), .edge_o(edge_pulse));

   always_comb begin
      cnt_d   = cnt_q;
      state_d = state_q;
      cand_d  = cand_q;
      mcnt_d  = mcnt_q;
      note_d  = note_q;
      hit     = classify(cnt_q, TOL);

      if (edge_pulse)          cnt_d = 11'd1;
      else if (cnt_q != TMO)   cnt_d = cnt_q + 11'd1;

      // An edge wins over saturation; a saturated M never matches a note.
      if (edge_pulse) begin
         if (state_q == IDLE) begin
            state_d = ARM;
            cand_d  = NOTE_NONE;
            mcnt_d  = 4'd0;
            note_d  = NOTE_NONE;
         end else if (hit == NOTE_NONE) begin
            state_d = MEASURE;
            cand_d  = NOTE_NONE;
            mcnt_d  = 4'd0;
            note_d  = NOTE_NONE;
         end else if (!(state_q == LOCKED && hit == note_q)) begin
            cand_d = hit;
            mcnt_d = (hit != cand_q) ? 4'd1 : (mcnt_q == 4'hf) ? mcnt_q : mcnt_q + 4'd1;
            if (mcnt_d >= NEED_W) begin
               state_d = LOCKED;
               note_d  = hit;
            end else begin
               state_d = MEASURE;
               note_d  = NOTE_NONE;
            end
         end
      end else if (cnt_d == TMO) begin
         state_d = IDLE;
         cand_d  = NOTE_NONE;
         mcnt_d  = 4'd0;
         note_d  = NOTE_NONE;
      end

      vld_d = (note_d != NOTE_NONE);
      sw_d  = onehot_of(note_d);
      fnd_d = fnd_of(note_d);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         cand_q  <= NOTE_NONE;
         mcnt_q  <= '0;
         note_q  <= NOTE_NONE;
         vld_q   <= 1'b0;
         sw_q    <= '0;
         fnd_q   <= FND_DIGIT[0];
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         cand_q  <= cand_d;
         mcnt_q  <= mcnt_d;
         note_q  <= note_d;
         vld_q   <= vld_d;
         sw_q    <= sw_d;
         fnd_q   <= fnd_d;
      end
   end

   assign io.note       = note_q;
   assign io.note_valid = vld_q;
   assign io.note_sw    = sw_q;
   assign io.FND_out    = fnd_q;
endmodule
